pipeline_stage_regs: RTL
========================

PIPELINE_STAGE_REGS -- requirements
Module: pipeline_stage_regs

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have inputs StallF, StallD, FlushD, FlushE, each 1 bit: hold/bubble requests from hazard logic.
REQ-005 SHALL have inputs PCNextF (32), InstrF (32), PCPlus4F (32): fetch-stage values.
REQ-006 SHALL have input CtrlD (10): {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc}.
REQ-007 SHALL have inputs RD1D, RD2D, ImmExtD (32 each) and Rs1D, Rs2D, RdD (5 each): decode-stage values.
REQ-008 SHALL have outputs PCF (32), InstrD (32), PCD (32), PCPlus4D (32) and ValidD (1).
REQ-009 SHALL have outputs CtrlE (10), RD1E, RD2E, ImmExtE, PCE, PCPlus4E (32 each), Rs1E, Rs2E, RdE (5 each) and ValidE (1).
REQ-010 SHALL have outputs StallCnt (32) and FlushCnt (32): performance counters.

Function
REQ-011 SHALL load PCF <= PCNextF on each clk edge where StallF=0, and hold PCF when StallF=1.
REQ-012 SHALL apply F/D register priority FlushD > StallD > capture.
- FlushD=1: InstrD, PCD, PCPlus4D all cleared to 0; ValidD=0.
- StallD=1: all D outputs held.
- Otherwise: capture InstrF, PCF, PCPlus4F; ValidD=1.
REQ-013 SHALL, when FlushE=1, clear CtrlE, all E data/address outputs and ValidE to 0 (bubble).
REQ-014 SHALL, when FlushE=0, capture every D-stage value into E and set ValidE <= ValidD; the E stage has no stall input.
REQ-015 SHALL give a latency of exactly one edge per stage: F->D one edge, D->E one edge.
REQ-016 SHALL, when StallD=1 and FlushE=1 together (load-use), hold D and bubble E in the same edge.
REQ-017 SHALL, when FlushD=1 and FlushE=1 together (taken branch), clear both stages in the same edge.
REQ-018 SHALL, when StallF=0 and StallD=1, advance PCF and hold D literally; no error is flagged.
REQ-019 SHALL increment StallCnt by 1 on each edge where StallF=1, saturating at 32'hFFFF_FFFF.
REQ-020 SHALL increment FlushCnt by 1 on each edge where FlushD=1 or FlushE=1 (once per edge even if both), saturating at 32'hFFFF_FFFF.
REQ-021 SHALL make all outputs pure register outputs, with no combinational input-to-output path.

Reset
REQ-022 SHALL, while rst=0, force immediately and regardless of clk: PCF=RESET_PC; every D and E output, ValidD, ValidE, StallCnt and FlushCnt = 0.
REQ-023 SHALL, on rst assertion mid-operation, discard in-flight stage contents with no completion of the pending edge.
REQ-024 SHALL, on the first edge after rst deasserts with no stall/flush, give ValidD=1 and PCD=RESET_PC.

Structure
REQ-025 SHALL place in shared package pipe_pkg: CTRL_W=10, the CtrlD bit-field offsets, and the default RESET_PC constant.
REQ-026 SHALL build stages from one sub-module pipe_reg: parameterized width, enable, synchronous clear, asynchronous active-low reset; clear has priority over enable.
REQ-027 SHALL implement the counters inline (no counter sub-module).

Verification
REQ-028 SHALL verify free-run: reset release, PCNextF = PCF+4 each cycle, InstrF=0x00500093 -> PCD=0, 4, 8 on successive edges; ValidE=1 from the second edge.
REQ-029 SHALL verify load-use: StallF=StallD=FlushE=1 for one cycle with InstrD=0x0000A103 -> PCF and InstrD hold, CtrlE=0, ValidE=0, StallCnt=1, FlushCnt=1.
REQ-030 SHALL verify branch: FlushD=FlushE=1 for one cycle -> InstrD=0, ValidD=0, ValidE=0, FlushCnt increments by 1 only.
REQ-031 SHALL verify priority: FlushD=1 and StallD=1 together -> D cleared, not held.
REQ-032 SHALL verify async reset: rst driven low between edges with ValidE=1, RdE=5'd7 -> RdE=0, ValidE=0, PCF=RESET_PC before the next edge.
REQ-033 SHALL verify saturation: StallCnt forced near max via a 0xFFFF_FFFE preload hook in the bench, StallF=1 for 3 cycles -> StallCnt stays at 0xFFFF_FFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline register slice: control-word layout and reset PC.
package pipe_pkg;

    localparam int unsigned CTRL_W = 10;

    // CtrlD = {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc}
    localparam int unsigned CTRL_REGWRITE      = 9;
    localparam int unsigned CTRL_RESULTSRC_LSB = 7;
    localparam int unsigned CTRL_MEMWRITE      = 6;
    localparam int unsigned CTRL_JUMP          = 5;
    localparam int unsigned CTRL_BRANCH        = 4;
    localparam int unsigned CTRL_ALUCTRL_LSB   = 1;
    localparam int unsigned CTRL_ALUSRC        = 0;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int unsigned D_W = 3 * 32 + 1;
    localparam int unsigned E_W = CTRL_W + 5 * 32 + 3 * 5 + 1;

endpackage

// File: rtl/pipe_reg.sv
// Generic stage register: async active-low reset, synchronous clear over enable.
module pipe_reg #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= RST_VAL;
        else if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pipeline_stage_regs.sv
// F, F/D and D/E pipeline registers with hazard hold/bubble controls and
// saturating stall/flush performance counters.
module pipeline_stage_regs
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              FlushE,
    input  logic [31:0]       PCNextF,
    input  logic [31:0]       InstrF,
    input  logic [31:0]       PCPlus4F,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [31:0]       RD1D,
    input  logic [31:0]       RD2D,
    input  logic [31:0]       ImmExtD,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        RdD,
    output logic [31:0]       PCF,
    output logic [31:0]       InstrD,
    output logic [31:0]       PCD,
    output logic [31:0]       PCPlus4D,
    output logic              ValidD,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [31:0]       RD1E,
    output logic [31:0]       RD2E,
    output logic [31:0]       ImmExtE,
    output logic [31:0]       PCE,
    output logic [31:0]       PCPlus4E,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic              ValidE,
    output logic [31:0]       StallCnt,
    output logic [31:0]       FlushCnt
);

    logic [D_W-1:0] d_q;
    logic [E_W-1:0] e_q;
    logic [31:0]    stall_cnt;
    logic [31:0]    flush_cnt;

    pipe_reg #(
        .WIDTH   (32),
        .RST_VAL (RESET_PC)
    ) u_reg_f (
        .clk   (clk),
        .rst_n (rst),
        .en    (!StallF),
        .clr   (1'b0),
        .d     (PCNextF),
        .q     (PCF)
    );

    pipe_reg #(
        .WIDTH (D_W)
    ) u_reg_d (
        .clk   (clk),
        .rst_n (rst),
        .en    (!StallD),
        .clr   (FlushD),
        .d     ({InstrF, PCF, PCPlus4F, 1'b1}),
        .q     (d_q)
    );

    assign {InstrD, PCD, PCPlus4D, ValidD} = d_q;

    // E has no stall: it always advances, or takes a bubble on FlushE.
    pipe_reg #(
        .WIDTH (E_W)
    ) u_reg_e (
        .clk   (clk),
        .rst_n (rst),
        .en    (1'b1),
        .clr   (FlushE),
        .d     ({CtrlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, ValidD}),
        .q     (e_q)
    );

    assign {CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE} = e_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallF && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
            if ((FlushD || FlushE) && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign StallCnt = stall_cnt;
    assign FlushCnt = flush_cnt;

endmodule
